// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN image loader and its core integration.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

    localparam int IMG_SIZE_DEF = 64;   // words per frame
    localparam int DATA_W_DEF   = 32;   // bits per pixel word

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } cnn_ld_state_e;

    // Write-counter width; never below one bit so tiny frames still get a counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(IMG_SIZE_DEF);

endpackage

// File: rtl/cnn_img_bank.sv
// Frame buffer: IMG_SIZE x DATA_W registers, one write port, whole frame visible on a flat bus.
// Latency: a write is visible on rd_flat the cycle after the we edge.
// Backpressure: none; accepts a write every cycle.
// Ports: clk, rst (async active-low clear), we/addr/wdata write port, rd_flat read bus.
module cnn_img_bank #(
    parameter int IMG_SIZE = 64,
    parameter int DATA_W   = 32,
    parameter int AW       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [AW-1:0]              addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [IMG_SIZE*DATA_W-1:0] rd_flat
);

    logic [IMG_SIZE*DATA_W-1:0] mem_q;
    logic [IMG_SIZE*DATA_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[int'(addr)*DATA_W +: DATA_W] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_flat = mem_q;

endmodule

// File: rtl/cnn_img_loader.sv
// Collects a pixel stream into a full frame, presents it to the CNN core and holds enable until done.
// Latency: cnn_enable rises the cycle after the last good word; falls the cycle after cnn_done.
// Backpressure: s_ready is registered and low while a frame is held for the core (a pending bank when
//   CNN_LOADER_PINGPONG_EN is defined, which adds a second bank so the next frame fills during RUN).
// Ports: s_valid/s_data/s_last/s_ready pixel stream in; img_flat/cnn_enable/cnn_done core side;
//   frame_err one-cycle discard pulse; busy status. Reset rst is asynchronous active-low.
module cnn_img_loader
    import cnn_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [IMG_SIZE*DATA_W-1:0] img_flat,
    output logic                       cnn_enable,
    input  logic                       cnn_done,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int               CNT_W    = cnt_w(IMG_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

    cnn_ld_state_e    state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             drop_q, drop_d;          // swallowing the tail of an over-long frame
    logic             s_ready_q, s_ready_d;
    logic             cnn_enable_q, cnn_enable_d;
    logic             frame_err_q, frame_err_d;
    logic             swap;                    // bank swap this cycle: forces one low enable cycle
`ifdef CNN_LOADER_PINGPONG_EN
    logic             wr_sel_q, wr_sel_d;      // bank being filled; the other one is displayed
    logic             pending_q, pending_d;    // wr bank holds a complete frame awaiting the core
`endif

    logic xfer, at_last, frame_ok, done_seen;

    assign xfer      = s_valid && s_ready_q;
    assign at_last   = (wr_cnt_q == LAST_IDX);
    assign frame_ok  = xfer && !drop_q && s_last && at_last;
    assign done_seen = cnn_enable_q && cnn_done;   // done is meaningless unless the core is enabled

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            wr_cnt_q     <= '0;
            drop_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            cnn_enable_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef CNN_LOADER_PINGPONG_EN
            wr_sel_q     <= 1'b0;
            pending_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            drop_q       <= drop_d;
            s_ready_q    <= s_ready_d;
            cnn_enable_q <= cnn_enable_d;
            frame_err_q  <= frame_err_d;
`ifdef CNN_LOADER_PINGPONG_EN
            wr_sel_q     <= wr_sel_d;
            pending_q    <= pending_d;
`endif
        end
    end

    // Next-state and write-counter logic
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        drop_d   = drop_q;
        swap     = 1'b0;
`ifdef CNN_LOADER_PINGPONG_EN
        wr_sel_d  = wr_sel_q;
        pending_d = pending_q;
`endif
        if (xfer) begin
            if (drop_q) begin
                if (s_last) begin
                    drop_d = 1'b0;
                end
            end else if (s_last || at_last) begin
                // End of frame, good or bad; a full count without s_last starts a drop.
                wr_cnt_d = '0;
                drop_d   = !s_last;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            FILL: begin
                if (frame_ok) begin
                    state_d = RUN;
`ifdef CNN_LOADER_PINGPONG_EN
                    wr_sel_d = ~wr_sel_q;
`endif
                end
            end
            RUN: begin
`ifdef CNN_LOADER_PINGPONG_EN
                // A frame finishing on the very done cycle is treated as already pending.
                if (done_seen && (pending_q || frame_ok)) begin
                    swap      = 1'b1;
                    wr_sel_d  = ~wr_sel_q;
                    pending_d = 1'b0;
                end else if (done_seen) begin
                    state_d = FILL;
                end else if (frame_ok) begin
                    pending_d = 1'b1;
                end
`else
                if (done_seen) begin
                    state_d = FILL;
                end
`endif
            end
            default: state_d = FILL;
        endcase
    end

    // Registered outputs
    always_comb begin
`ifdef CNN_LOADER_PINGPONG_EN
        s_ready_d = !pending_d;
`else
        s_ready_d = (state_d == FILL);
`endif
        cnn_enable_d = (state_d == RUN) && !swap;
        frame_err_d  = xfer && !drop_q && (s_last != at_last);
    end

    assign s_ready    = s_ready_q;
    assign cnn_enable = cnn_enable_q;
    assign frame_err  = frame_err_q;

    logic bank_we;
    assign bank_we = xfer && !drop_q;

`ifdef CNN_LOADER_PINGPONG_EN
    logic [IMG_SIZE*DATA_W-1:0] flat0, flat1;

    cnn_img_bank #(.IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W), .AW(CNT_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we && !wr_sel_q),
        .addr    (wr_cnt_q),
        .wdata   (s_data),
        .rd_flat (flat0)
    );

    cnn_img_bank #(.IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W), .AW(CNT_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we && wr_sel_q),
        .addr    (wr_cnt_q),
        .wdata   (s_data),
        .rd_flat (flat1)
    );

    // Read bank is always the one not being filled.
    assign img_flat = wr_sel_q ? flat0 : flat1;
    assign busy     = (state_q == RUN) || (wr_cnt_q != '0) || pending_q;
`else
    cnn_img_bank #(.IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W), .AW(CNT_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .addr    (wr_cnt_q),
        .wdata   (s_data),
        .rd_flat (img_flat)
    );

    assign busy = (state_q == RUN) || (wr_cnt_q != '0);
`endif

endmodule

// File: tb/tb_cnn_img_loader.sv
// Self-checking bench for cnn_img_loader: frame-level reference model, random data and gaps.
// Latency: n/a.
// Backpressure: n/a.
module tb_cnn_img_loader;

    localparam int IMG_SIZE = 64;
    localparam int DATA_W   = 32;
`ifdef CNN_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       s_valid;
    logic [DATA_W-1:0]          s_data;
    logic                       s_last;
    logic                       s_ready;
    logic [IMG_SIZE*DATA_W-1:0] img_flat;
    logic                       cnn_enable;
    logic                       cnn_done;
    logic                       frame_err;
    logic                       busy;

    cnn_img_loader #(.IMG_SIZE(IMG_SIZE), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .img_flat   (img_flat),
        .cnn_enable (cnn_enable),
        .cnn_done   (cnn_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int launches = 0;
    logic en_prev = 1'b0;
    logic [DATA_W-1:0] exp_img [IMG_SIZE];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: counts frame_err cycles and rising edges of cnn_enable.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
        if (cnn_enable === 1'b1 && !en_prev) launches++;
        en_prev = (cnn_enable === 1'b1);
    end

    function automatic int img_mism();
        int m = 0;
        for (int i = 0; i < IMG_SIZE; i++) begin
            if (img_flat[i*DATA_W +: DATA_W] !== exp_img[i]) m++;
        end
        return m;
    endfunction

    // Called just after a negedge; returns just after the negedge following the transfer edge.
    task automatic put_word(input logic [DATA_W-1:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 64'(t), 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // mode 0: random words, 1: all ones, 2: word i = i. A frame is good iff it has exactly IMG_SIZE words.
    task automatic send_frame(input int len, input int mode, input int max_gap);
        logic [DATA_W-1:0] w;
        bit good;
        int err0, l0;
        good = (len == IMG_SIZE);
        err0 = err_pulses;
        l0   = launches;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       w = DATA_W'($urandom);
                1:       w = 1;
                default: w = DATA_W'(i);
            endcase
            if (good) exp_img[i] = w;
            put_word(w, i == len - 1);
            #1;
            if (i == 2 && len > 3) chk("busy_partial", busy, 1);
            if (len > IMG_SIZE && i == IMG_SIZE - 1) chk("err_long_timing", frame_err, 1);
            if (len < IMG_SIZE && i == len - 1) chk("err_short_timing", frame_err, 1);
            if (i == len - 1) begin
                chk("launch_latency", cnn_enable, good);
                if (good) begin
                    chk("img_words", 64'(img_mism()), 0);
                    chk("ready_in_run", s_ready, PP);
                end
            end else if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
        end
        @(negedge clk);
        #1;
        chk("err_count", 64'(err_pulses - err0), good ? 0 : 1);
        chk("launch_count", 64'(launches - l0), good ? 1 : 0);
    endtask

    task automatic finish_run(input int wait_cyc);
        repeat (wait_cyc) @(negedge clk);
        chk("enable_held", cnn_enable, 1);
        chk("img_frozen", 64'(img_mism()), 0);
        cnn_done = 1'b1;
        @(negedge clk);
        cnn_done = 1'b0;
        #1;
        chk("enable_release", cnn_enable, 0);
        chk("ready_release", s_ready, 1);
        chk("busy_release", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        cnn_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", s_ready, 0);
        chk("rst_enable", cnn_enable, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_img", 64'(img_flat != '0), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", s_ready, 0);
        @(negedge clk);
        #1;
        chk("ready_after_release", s_ready, 1);

        // Good frame of ones, no gaps, done 20 cycles after launch.
        send_frame(IMG_SIZE, 1, 0);
        finish_run(19);

        // Done asserted while idle must be ignored.
        cnn_done = 1'b1;
        repeat (3) @(negedge clk);
        cnn_done = 1'b0;
        #1;
        chk("done_in_fill", cnn_enable, 0);

        // Short frame (s_last on word 10), then word i = i.
        send_frame(11, 0, 0);
        send_frame(IMG_SIZE, 2, 1);
        finish_run($urandom_range(1, 10));

        // Long frame of 70 words, then a normal frame.
        send_frame(70, 0, 0);
        send_frame(IMG_SIZE, 0, 2);
        finish_run(3);

        // Done held high across the launch: counts on the first enabled cycle only.
        cnn_done = 1'b1;
        send_frame(IMG_SIZE, 0, 0);
        chk("held_done_release", cnn_enable, 0);
        chk("held_done_ready", s_ready, 1);
        cnn_done = 1'b0;

        // Random frame mix.
        for (int k = 0; k < 8; k++) begin
            int sel, len;
            sel = $urandom_range(0, 2);
            len = (sel == 0) ? $urandom_range(1, IMG_SIZE - 1)
                : (sel == 1) ? $urandom_range(IMG_SIZE + 1, IMG_SIZE + 8) : IMG_SIZE;
            send_frame(len, 0, 2);
            if (len == IMG_SIZE) finish_run($urandom_range(1, 12));
        end

        // Reset in the middle of RUN.
        send_frame(IMG_SIZE, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_enable", cnn_enable, 0);
        chk("midrst_img", 64'(img_flat != '0), 0);
        chk("midrst_ready", s_ready, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_ready_back", s_ready, 1);
        send_frame(IMG_SIZE, 0, 1);
        finish_run(3);

`ifdef CNN_LOADER_PINGPONG_EN
        begin
            logic [DATA_W-1:0] b_img [IMG_SIZE];
            send_frame(IMG_SIZE, 0, 0);
            for (int i = 0; i < IMG_SIZE; i++) begin
                b_img[i] = DATA_W'($urandom);
                put_word(b_img[i], i == IMG_SIZE - 1);
            end
            #1;
            chk("pp_ready_pending", s_ready, 0);
            chk("pp_enable_a", cnn_enable, 1);
            chk("pp_img_a", 64'(img_mism()), 0);
            for (int i = 0; i < IMG_SIZE; i++) exp_img[i] = b_img[i];
            cnn_done = 1'b1;
            @(negedge clk);
            cnn_done = 1'b0;
            #1;
            chk("pp_gap", cnn_enable, 0);
            @(negedge clk);
            #1;
            chk("pp_relaunch", cnn_enable, 1);
            chk("pp_img_b", 64'(img_mism()), 0);
            chk("pp_ready_after_swap", s_ready, 1);
            finish_run(2);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
